ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader.sv | 140 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream bytes LSB-first onto ccff_head.
// Define CCFF_TAIL_CHECK_EN to add the tail-parity integrity check that drives chain_err.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic       prog_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       ccff_tail,
    output logic       ccff_head,
    output logic       prog_clk_en,
    output logic       busy,
    output logic       cfg_done,
    output logic       chain_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

    state_t           state;
    logic [7:0]       byte_buf;
    logic             buf_full;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] bit_cnt;
    logic             last_bit;
    logic             take;

`ifdef CCFF_TAIL_CHECK_EN
    logic tail_par;
    logic head_par;
    logic last_par;
    logic prev_valid;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign chain_err   = 1'b0;
`endif

    // A new byte may land on the same edge that shifts bit 7, unless that bit ends the load.
    assign last_bit = (bit_cnt == LAST_CNT);
    assign in_ready = (state == SHIFT) && !abort &&
                      (!buf_full || ((bit_idx == 3'd7) && !last_bit));
    assign take     = in_valid && in_ready;

    always_ff @(posedge prog_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            byte_buf    <= '0;
            buf_full    <= 1'b0;
            bit_idx     <= '0;
            bit_cnt     <= '0;
            ccff_head   <= 1'b0;
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            cfg_done    <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
            tail_par    <= 1'b0;
            head_par    <= 1'b0;
            last_par    <= 1'b0;
            prev_valid  <= 1'b0;
            chain_err   <= 1'b0;
`endif
        end else if (abort) begin
            state       <= IDLE;
            buf_full    <= 1'b0;
            bit_idx     <= '0;
            bit_cnt     <= '0;
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            cfg_done    <= 1'b0;
        end else begin
            prog_clk_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        buf_full <= 1'b0;
                        busy     <= 1'b1;
                        cfg_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (buf_full) begin
                        ccff_head   <= byte_buf[bit_idx];
                        prog_clk_en <= 1'b1;
                        bit_idx     <= bit_idx + 3'd1;
                        if (bit_cnt != FULL_CNT)
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_idx == 3'd7)
                            buf_full <= 1'b0;
                        if (last_bit) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            cfg_done <= 1'b1;
                            buf_full <= 1'b0;
                        end
                    end
                    if (take) begin
                        byte_buf <= in_data;
                        buf_full <= 1'b1;
                        bit_idx  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

`ifdef CCFF_TAIL_CHECK_EN
            if (prog_clk_en) begin
                tail_par <= tail_par ^ ccff_tail;
                head_par <= head_par ^ ccff_head;
            end
            // The final shift is still enabled in the first DONE cycle, so the check folds it in here.
            if ((state == DONE) && prog_clk_en) begin
                if (prev_valid && ((tail_par ^ ccff_tail) != last_par))
                    chain_err <= 1'b1;
                last_par   <= head_par ^ ccff_head;
                prev_valid <= 1'b1;
            end
            if (start && (state != SHIFT)) begin
                tail_par <= 1'b0;
                head_par <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed self-checking bench for ccff_chain_loader (16-bit and 12-bit chain instances).
// The tail-parity section is compiled only when CCFF_TAIL_CHECK_EN is defined.
module tb_ccff_chain_loader;

    logic       prog_clk = 1'b0;
    logic       reset    = 1'b0;
    logic       start16  = 1'b0;
    logic       start12  = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       flip_req = 1'b0;

    logic        rdy16, head16, en16, busy16, done16, err16, tail16;
    logic        rdy12, head12, en12, busy12, done12, err12;
    logic [15:0] chain = 16'h0000;

    int total = 0;
    int bad   = 0;

    logic [7:0]  byte_q[$];
    int          en_cnt, first_en, last_en, done_cyc;
    logic [15:0] bits;
    logic        rdy_at_done;
    logic        obs_en, obs_busy, obs_done, obs_head, obs_rdy;

    ccff_chain_loader #(.CHAIN_LEN(16)) u_dut16 (
        .prog_clk   (prog_clk),
        .reset      (reset),
        .start      (start16),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (rdy16),
        .ccff_tail  (tail16),
        .ccff_head  (head16),
        .prog_clk_en(en16),
        .busy       (busy16),
        .cfg_done   (done16),
        .chain_err  (err16)
    );

    ccff_chain_loader #(.CHAIN_LEN(12)) u_dut12 (
        .prog_clk   (prog_clk),
        .reset      (reset),
        .start      (start12),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (rdy12),
        .ccff_tail  (1'b0),
        .ccff_head  (head12),
        .prog_clk_en(en12),
        .busy       (busy12),
        .cfg_done   (done12),
        .chain_err  (err12)
    );

    always #5 prog_clk = ~prog_clk;

    // Downstream 16-bit chain model; flip_req corrupts one stored bit while the chain is idle.
    assign tail16 = chain[15];
    always @(posedge prog_clk) begin
        if (en16)
            chain <= {chain[14:0], head16};
        else if (flip_req)
            chain <= chain ^ 16'h0008;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses start, then runs n cycles (cycle 0 = first cycle after the start edge) feeding byte_q.
    task automatic applyStimulus(input bit sel12, input int stall_at, input int stall_len,
                                 input int abort_at, input int n);
        en_cnt      = 0;
        first_en    = -1;
        last_en     = -1;
        done_cyc    = -1;
        bits        = 16'h0000;
        rdy_at_done = 1'b1;
        @(negedge prog_clk);
        if (sel12) start12 = 1'b1;
        else       start16 = 1'b1;
        for (int j = 0; j < n; j++) begin
            @(negedge prog_clk);
            start12  = 1'b0;
            start16  = 1'b0;
            abort    = (j == abort_at);
            in_valid = (byte_q.size() > 0) && !((j >= stall_at) && (j < stall_at + stall_len));
            in_data  = (byte_q.size() > 0) ? byte_q[0] : 8'h00;
            #1;
            obs_en   = sel12 ? en12   : en16;
            obs_head = sel12 ? head12 : head16;
            obs_busy = sel12 ? busy12 : busy16;
            obs_done = sel12 ? done12 : done16;
            obs_rdy  = sel12 ? rdy12  : rdy16;
            if (obs_en) begin
                if (en_cnt < 16) bits[en_cnt] = obs_head;
                if (first_en < 0) first_en = j;
                last_en = j;
                en_cnt++;
            end
            if (obs_done && (done_cyc < 0)) begin
                done_cyc    = j;
                rdy_at_done = obs_rdy;
            end
            if (in_valid && obs_rdy)
                void'(byte_q.pop_front());
        end
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        #1;
        checkOutput("rst_head", 32'(head16), 32'd0);
        checkOutput("rst_en",   32'(en16),   32'd0);
        checkOutput("rst_busy", 32'(busy16), 32'd0);
        checkOutput("rst_done", 32'(done16), 32'd0);
        checkOutput("rst_rdy",  32'(rdy16),  32'd0);
        checkOutput("rst_err",  32'(err16),  32'd0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        reset = 1'b1;

        // Basic load: 0xA5 then 0x3C back to back
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, -1, 24);
        checkOutput("basic_bits",  32'(bits),     32'h3CA5);
        checkOutput("basic_encnt", 32'(en_cnt),   32'd16);
        checkOutput("basic_first", 32'(first_en), 32'd2);
        checkOutput("basic_last",  32'(last_en),  32'd17);
        checkOutput("basic_done",  32'(done_cyc), 32'd17);
        checkOutput("basic_busy",  32'(obs_busy), 32'd0);
        checkOutput("basic_dhold", 32'(obs_done), 32'd1);

        // Starvation: in_valid low for 5 cycles between the bytes
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 8, 5, -1, 28);
        checkOutput("starve_bits",  32'(bits),     32'h3CA5);
        checkOutput("starve_encnt", 32'(en_cnt),   32'd16);
        checkOutput("starve_gap",   32'(last_en - first_en + 1 - en_cnt), 32'd5);
        checkOutput("starve_done",  32'(done_cyc), 32'd22);

        // Partial final byte on the 12-bit chain
        byte_q = '{8'hFF, 8'h0F};
        applyStimulus(1'b1, 0, 0, -1, 20);
        checkOutput("part_bits",  32'(bits),        32'h0FFF);
        checkOutput("part_encnt", 32'(en_cnt),      32'd12);
        checkOutput("part_last",  32'(last_en),     32'd13);
        checkOutput("part_done",  32'(done_cyc),    32'd13);
        checkOutput("part_rdy",   32'(rdy_at_done), 32'd0);

        // Abort during the 8th bit
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, 8, 10);
        checkOutput("abort_encnt", 32'(en_cnt),   32'd7);
        checkOutput("abort_en",    32'(obs_en),   32'd0);
        checkOutput("abort_busy",  32'(obs_busy), 32'd0);
        checkOutput("abort_done",  32'(obs_done), 32'd0);

        // Asynchronous reset in the middle of a load
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, -1, 11);
        checkOutput("prerst_busy", 32'(busy16), 32'd1);
        checkOutput("prerst_en",   32'(en16),   32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_en",   32'(en16),   32'd0);
        checkOutput("midrst_busy", 32'(busy16), 32'd0);
        checkOutput("midrst_done", 32'(done16), 32'd0);
        checkOutput("midrst_head", 32'(head16), 32'd0);
        checkOutput("midrst_rdy",  32'(rdy16),  32'd0);
        @(negedge prog_clk);
        reset = 1'b1;

        // Full reload after reset
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, -1, 24);
        checkOutput("reload_bits",  32'(bits),     32'h3CA5);
        checkOutput("reload_encnt", 32'(en_cnt),   32'd16);
        checkOutput("reload_done",  32'(done_cyc), 32'd17);

`ifdef CCFF_TAIL_CHECK_EN
        // Tail parity: clean reload, corrupt the chain, then reload twice more
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, -1, 24);
        checkOutput("tail_clean", 32'(err16), 32'd0);
        @(negedge prog_clk);
        flip_req = 1'b1;
        @(negedge prog_clk);
        flip_req = 1'b0;
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, -1, 24);
        checkOutput("tail_corrupt", 32'(err16), 32'd1);
        byte_q = '{8'hA5, 8'h3C};
        applyStimulus(1'b0, 0, 0, -1, 24);
        checkOutput("tail_sticky", 32'(err16), 32'd1);
        checkOutput("tail_bits",   32'(bits),  32'h3CA5);
`else
        checkOutput("err_tied", 32'(err16), 32'd0);
        checkOutput("err12_tied", 32'(err12), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
